// File: rtl/filter_coef_ctrl.sv
// rtl/filter_coef_ctrl.sv - shadow/active coefficient banks for the 5x5 Y-channel filter
// Host writes the shadow bank; a commit is copied to the active bank at the next frame start.
module filter_coef_ctrl #(
  parameter int COEF_WIDTH = 10,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_vs,
  input  logic                    i_wr_en,
  input  logic [ADDR_WIDTH-1:0]   i_wr_addr,
  input  logic [COEF_WIDTH-1:0]   i_wr_data,
  output logic                    o_wr_ready,
  input  logic                    i_commit,
  input  logic [ADDR_WIDTH-1:0]   i_rd_addr,
  output logic [COEF_WIDTH-1:0]   o_rd_data,
  input  logic                    i_err_clr,
  output logic                    o_err,
  output logic                    o_pending,
  output logic                    o_apply_done,
  output logic                    o_bypass,
  output logic [25*COEF_WIDTH-1:0] o_coef
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PEND  = 2'd1;
  localparam logic [1:0] S_APPLY = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] BYP_ADDR = ADDR_WIDTH'(25);

  logic [1:0]            state;
  logic                  vs_d;
  logic                  vs_rise;
  logic                  vs_rise_q;
  logic [COEF_WIDTH-1:0] shadow [25];
  logic [COEF_WIDTH-1:0] active [25];
  logic                  shadow_byp;
  logic                  active_byp;
  logic                  in_idle;
  logic                  addr_ok;
  logic                  wr_fire;
  logic                  err_set;
  logic [COEF_WIDTH-1:0] rd_next;

  assign vs_rise = i_vs & ~vs_d;
  assign in_idle = (state == S_IDLE);
  assign addr_ok = (i_wr_addr <= BYP_ADDR);
  assign wr_fire = i_wr_en & in_idle & addr_ok;
  assign err_set = (i_wr_en & (~in_idle | ~addr_ok)) | (i_commit & ~in_idle);

  assign o_wr_ready   = in_idle & ~rst;
  assign o_pending    = (state == S_PEND) | (state == S_APPLY);
  assign o_apply_done = (state == S_APPLY);
  assign o_bypass     = active_byp;

  for (genvar g = 0; g < 25; g++) begin : g_pack
    assign o_coef[g*COEF_WIDTH +: COEF_WIDTH] = active[g];
  end

  // Edge qualified only while pending, so a rise coinciding with the commit is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      vs_d      <= 1'b0;
      vs_rise_q <= 1'b0;
    end else begin
      vs_d      <= i_vs;
      vs_rise_q <= vs_rise & (state == S_PEND);
      case (state)
        S_IDLE:  if (i_commit) state <= S_PEND;
        S_PEND:  if (vs_rise_q) state <= S_APPLY;
        S_APPLY: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 25; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      shadow_byp <= 1'b1;
      active_byp <= 1'b1;
    end else begin
      if (wr_fire) begin
        if (i_wr_addr == BYP_ADDR) shadow_byp <= i_wr_data[0];
        else                       shadow[i_wr_addr] <= i_wr_data;
      end
      if (state == S_APPLY) begin
        for (int i = 0; i < 25; i++) active[i] <= shadow[i];
        active_byp <= shadow_byp;
      end
    end
  end

  always_comb begin
    rd_next = '0;
    if (i_rd_addr < BYP_ADDR)       rd_next = shadow[i_rd_addr];
    else if (i_rd_addr == BYP_ADDR) rd_next = {{(COEF_WIDTH-1){1'b0}}, shadow_byp};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rd_data <= '0;
      o_err     <= 1'b0;
    end else begin
      o_rd_data <= rd_next;
      if (err_set)        o_err <= 1'b1;
      else if (i_err_clr) o_err <= 1'b0;
    end
  end

endmodule
